// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Sequential Y86-64 fetch stage. On an accepted start it walks the
// instruction at pc one byte per handshake from a byte-wide instruction
// memory. It decodes icode/ifun/rA/rB/valC, computes valP and raises a
// one-cycle done pulse for decode/execute and the PC-update stage.
//
// Ports
//   clk, rst            clock (posedge), asynchronous active-high reset
//   start, pc           fetch request and address (sampled in IDLE only)
//   imem_rd, imem_addr  byte read request / address
//   imem_data           read data, valid when imem_ready=1
//   imem_ready          memory completes the read this cycle
//   icode, ifun         byte0 fields
//   rA, rB              register byte fields (4'hF when absent)
//   valC                little-endian constant (0 when absent)
//   valP                pc + instruction length, modulo 2^PC_W
//   stat                1=AOK 2=HLT 3=ADR 4=INS
//   busy                high whenever not IDLE
//   done                one-cycle pulse, outputs valid
// ----------------------------------------------------------------------------
module fetch_unit #(
   parameter int PC_W     = 11,
   parameter int MEM_SIZE = 2048
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [PC_W-1:0] pc,
   output logic            imem_rd,
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_data,
   input  logic            imem_ready,
   output logic [3:0]      icode,
   output logic [3:0]      ifun,
   output logic [3:0]      rA,
   output logic [3:0]      rB,
   output logic [63:0]     valC,
   output logic [PC_W-1:0] valP,
   output logic [2:0]      stat,
   output logic            busy,
   output logic            done
);

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [PC_W:0] MEM_LIM = MEM_SIZE[PC_W:0];
   localparam logic [PC_W:0] ONE_EXT = {{PC_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, BYTE0, REGS, CONST, DONE} state_t;

   state_t          state;
   logic [PC_W-1:0] base;
   logic [3:0]      offset;   // bytes already captured for this instruction
   logic [2:0]      cidx;     // next valC byte lane

   logic [PC_W:0]   addr_ext; // one extra bit so running off the end is visible
   logic [PC_W:0]   addr_nxt;
   logic            rd_state;
   logic            addr_ok;

   assign addr_ext = {1'b0, base} + {{(PC_W-3){1'b0}}, offset};
   assign addr_nxt = addr_ext + ONE_EXT;
   assign rd_state = (state == BYTE0) || (state == REGS) || (state == CONST);
   assign addr_ok  = (addr_ext < MEM_LIM);

   // Read request and address are pure decodes of registered state.
   assign imem_rd   = rd_state && addr_ok;
   assign imem_addr = rd_state ? addr_ext[PC_W-1:0] : '0;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         base   <= '0;
         offset <= '0;
         cidx   <= '0;
         icode  <= 4'h0;
         ifun   <= 4'h0;
         rA     <= 4'hF;
         rB     <= 4'hF;
         valC   <= '0;
         valP   <= '0;
         stat   <= S_AOK;
      end else if (rd_state && !addr_ok) begin
         // Next byte lies outside memory: abandon without reading.
         stat  <= S_ADR;
         state <= DONE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base   <= pc;
                  offset <= '0;
                  stat   <= S_AOK;
                  rA     <= 4'hF;
                  rB     <= 4'hF;
                  valC   <= '0;
                  state  <= BYTE0;
               end
            end
            BYTE0: begin
               if (imem_ready) begin
                  icode  <= imem_data[7:4];
                  ifun   <= imem_data[3:0];
                  offset <= offset + 4'd1;
                  cidx   <= '0;
                  case (imem_data[7:4])
                     4'h0: begin
                        stat  <= S_HLT;
                        valP  <= addr_nxt[PC_W-1:0];
                        state <= DONE;
                     end
                     4'h1, 4'h9: begin
                        valP  <= addr_nxt[PC_W-1:0];
                        state <= DONE;
                     end
                     4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: state <= REGS;
                     4'h7, 4'h8: state <= CONST;
                     default: begin
                        stat  <= S_INS;
                        state <= DONE;
                     end
                  endcase
               end
            end
            REGS: begin
               if (imem_ready) begin
                  rA     <= imem_data[7:4];
                  rB     <= imem_data[3:0];
                  offset <= offset + 4'd1;
                  if (icode == 4'h3 || icode == 4'h4 || icode == 4'h5) begin
                     state <= CONST;
                  end else begin
                     valP  <= addr_nxt[PC_W-1:0];
                     state <= DONE;
                  end
               end
            end
            CONST: begin
               if (imem_ready) begin
                  valC[{cidx, 3'b000} +: 8] <= imem_data;
                  offset <= offset + 4'd1;
                  cidx   <= cidx + 3'd1;
                  if (cidx == 3'd7) begin
                     valP  <= addr_nxt[PC_W-1:0];
                     state <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Randomized scoreboard bench for fetch_unit. The driver loads instruction
// bytes, predicts the fetch result from the instruction-format rules and
// queues it; an independent monitor pops and compares on every done pulse,
// and also tracks read addresses, stall behaviour, read count and latency.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int PC_W = 11;
   localparam int MSZ  = 2048;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [PC_W-1:0] pc;
   logic            imem_rd;
   logic [PC_W-1:0] imem_addr;
   logic [7:0]      imem_data;
   logic            imem_ready;
   logic [3:0]      icode, ifun, rA, rB;
   logic [63:0]     valC;
   logic [PC_W-1:0] valP;
   logic [2:0]      stat;
   logic            busy, done;

   logic [7:0] mem [0:MSZ-1];
   assign imem_data = mem[imem_addr];

   fetch_unit #(.PC_W(PC_W), .MEM_SIZE(MSZ)) dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
      .imem_ready(imem_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .stat(stat), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] pc;
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc;
      logic [10:0] valp;
      logic [2:0]  stat;
      int          reads;
      int          lat;
      int          mode;
   } exp_t;

   exp_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          mode = 0;        // 0 ready high, 1 random, 2 toggle
   int          done_cnt = 0;
   logic [10:0] prev_valp = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: derived from instruction lengths and field layout only.
   function automatic exp_t model(input logic [10:0] p, input logic [10:0] pv, input int md);
      exp_t e;
      int len, avail, cst;
      logic [7:0] b;
      e.pc = p; e.mode = md;
      e.stat = 3'd1; e.ra = 4'hF; e.rb = 4'hF; e.valc = '0; e.valp = pv;
      b = mem[p];
      e.icode = b[7:4]; e.ifun = b[3:0];
      if (e.icode > 4'hB) begin
         e.stat = 3'd4; e.reads = 1; e.lat = 2;
         return e;
      end
      case (e.icode)
         4'h0, 4'h1, 4'h9:             len = 1;
         4'h2, 4'h6, 4'hA, 4'hB:       len = 2;
         4'h7, 4'h8:                   len = 9;
         default:                      len = 10;
      endcase
      avail = MSZ - int'(p);
      if (len > avail) begin
         e.stat = 3'd3; e.reads = avail; e.lat = avail + 2;
      end else begin
         e.reads = len; e.lat = len + 1;
         e.valp = 11'((int'(p) + len) % 2048);
         if (e.icode == 4'h0) e.stat = 3'd2;
      end
      if (len >= 2 && e.icode != 4'h7 && e.icode != 4'h8 && e.reads >= 2) begin
         b = mem[int'(p) + 1];
         e.ra = b[7:4]; e.rb = b[3:0];
      end
      cst = (e.icode == 4'h7 || e.icode == 4'h8) ? 1 : (len == 10 ? 2 : 0);
      if (cst > 0)
         for (int k = 0; k < 8; k++)
            if (cst + k < e.reads) e.valc[8*k +: 8] = mem[int'(p) + cst + k];
      return e;
   endfunction

   // Memory handshake generator, updated just after each rising edge.
   always @(posedge clk) begin
      #2;
      case (mode)
         0:       imem_ready = 1'b1;
         1:       imem_ready = ($urandom_range(0, 2) != 0);
         default: imem_ready = ~imem_ready;
      endcase
   end

   // Monitor / scoreboard checker.
   int          cyc, reads;
   logic        pbusy = 1'b0, pstall = 1'b0;
   logic [10:0] paddr;
   always @(negedge clk) begin
      if (rst) begin
         pbusy = 1'b0; pstall = 1'b0;
      end else begin
         if (busy) begin
            if (!pbusy) begin cyc = 0; reads = 0; end
            cyc++;
         end
         if (pstall) begin
            chk("stall_rd", imem_rd, 1'b1);
            chk("stall_addr", imem_addr, paddr);
         end
         if (imem_rd) begin
            if (q.size() > 0) chk("rd_addr", imem_addr, int'(q[0].pc) + reads);
            if (imem_ready) reads++;
         end
         pstall = imem_rd && !imem_ready;
         paddr  = imem_addr;
         if (done) begin
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_done: got done=1 expected no pending fetch at %0t", $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("icode", icode, e.icode);
               chk("ifun", ifun, e.ifun);
               chk("rA", rA, e.ra);
               chk("rB", rB, e.rb);
               chk("valC", valC, e.valc);
               chk("valP", valP, e.valp);
               chk("stat", stat, e.stat);
               chk("reads", reads, e.reads);
               if (e.mode == 0) chk("latency", cyc, e.lat);
            end
            done_cnt++;
         end
         pbusy = busy;
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 300) begin @(negedge clk); n++; end
      if (busy) begin
         miscompares++;
         $display("FAIL idle_timeout: got busy=1 expected 0 after %0d cycles", n);
      end
      #1;
   endtask

   task automatic load(input logic [10:0] p, input logic [7:0] b [10]);
      for (int k = 0; k < 10; k++)
         if (int'(p) + k < MSZ) mem[int'(p) + k] = b[k];
   endtask

   task automatic issue(input logic [10:0] p, input int md);
      exp_t e;
      mode = md;
      e = model(p, prev_valp, md);
      prev_valp = e.valp;
      q.push_back(e);
      start = 1'b1; pc = p;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_imem_rd", imem_rd, 1'b0);
      chk("rst_imem_addr", imem_addr, 11'h0);
      chk("rst_icode", icode, 4'h0);
      chk("rst_ifun", ifun, 4'h0);
      chk("rst_rA", rA, 4'hF);
      chk("rst_rB", rB, 4'hF);
      chk("rst_valC", valC, 64'h0);
      chk("rst_valP", valP, 11'h0);
      chk("rst_stat", stat, 3'd1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
   endtask

   logic [7:0] bytes [10];
   initial begin
      rst = 1'b1; start = 1'b0; pc = '0; imem_ready = 1'b1;
      for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      chk_reset_vals();
      #1 rst = 1'b0;

      // Reset in the middle of an irmovq constant.
      wait_idle();
      bytes = '{8'h30, 8'hF2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(11'h200, bytes);
      issue(11'h200, 0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      q.delete(); prev_valp = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      @(posedge clk); #2 rst = 1'b0;

      // irmovq $10, %rdx at 0x000.
      wait_idle();
      bytes = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load(11'h000, bytes);
      issue(11'h000, 0);

      // jXX at 0x100 with toggling ready.
      wait_idle();
      bytes = '{8'h74, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
      load(11'h100, bytes);
      issue(11'h100, 2);

      // halt at 0x005.
      wait_idle();
      mem[5] = 8'h00;
      issue(11'h005, 0);

      // invalid icode at 0x010.
      wait_idle();
      mem[16] = 8'hC0;
      issue(11'h010, 0);

      // rmmovq running off the end of memory.
      wait_idle();
      bytes = '{8'h40, 8'h12, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load(11'h7FC, bytes);
      issue(11'h7FC, 0);

      // Back-to-back: start held through done is taken on the next IDLE.
      wait_idle();
      begin
         exp_t e1, e2;
         int base_cnt, n;
         mode = 0;
         mem[11'h300] = 8'h10;
         e1 = model(11'h300, prev_valp, 0);
         e2 = model(11'h300, e1.valp, 0);
         prev_valp = e2.valp;
         q.push_back(e1); q.push_back(e2);
         base_cnt = done_cnt; n = 0;
         start = 1'b1; pc = 11'h300;
         @(negedge clk);
         while (done_cnt < base_cnt + 2 && n < 50) begin @(negedge clk); n++; end
         #1 start = 1'b0;
         chk("b2b_dones", done_cnt - base_cnt, 2);
      end

      // Randomized instruction stream.
      for (int it = 0; it < 150; it++) begin
         logic [10:0] p;
         logic [3:0]  ic;
         wait_idle();
         p  = ($urandom_range(0, 7) == 0) ? 11'(MSZ - $urandom_range(1, 10)) : 11'($urandom);
         ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
         bytes[0] = {ic, 4'($urandom)};
         for (int k = 1; k < 10; k++) bytes[k] = 8'($urandom);
         load(p, bytes);
         issue(p, $urandom_range(0, 2));
      end

      wait_idle();
      begin
         int n = 0;
         while (q.size() > 0 && n < 20) begin @(negedge clk); n++; end
         if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
